apb3_rr_master_arb: RTL and testbench

//  Two-client round-robin arbiter and sequencer for one APB3 master port. Sits in front of the

---
 rtl/apb3_rr_master_arb.sv | 126 ++++++++++++
 tb/tb_apb3_rr_master_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_rr_master_arb.sv
// Two-client round-robin arbiter that sequences single APB3 transfers (SETUP/ACCESS) and
// aborts an ACCESS phase when PREADY stays low for TIMEOUT cycles.
module apb3_rr_master_arb #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  REQ0,
    input  logic                  WR0,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    input  logic [DATA_WIDTH-1:0] WDATA0,
    output logic                  ACK0,
    output logic [DATA_WIDTH-1:0] RDATA0,
    output logic                  ERR0,
    input  logic                  REQ1,
    input  logic                  WR1,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [DATA_WIDTH-1:0] WDATA1,
    output logic                  ACK1,
    output logic [DATA_WIDTH-1:0] RDATA1,
    output logic                  ERR1,
    output logic                  GNT_ID,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

    state_e              state;
    logic                last_gnt;
    logic [CntWidth-1:0] wait_cnt;
    logic                any_req;
    logic                winner;
    logic                finish;
    logic                timed_out;
    logic                err_val;
    logic [DATA_WIDTH-1:0] rdata_val;

    always_comb begin
        any_req   = REQ0 | REQ1;
        // On a tie the client that did not win last time gets the bus.
        winner    = REQ1 & (~REQ0 | ~last_gnt);
        timed_out = ~PREADY & (wait_cnt == CntLast);
        finish    = PREADY | timed_out;
        err_val   = timed_out | PSLVERR;
        rdata_val = timed_out ? '0 : PRDATA;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= StIdle;
            last_gnt <= 1'b1;
            wait_cnt <= '0;
            GNT_ID   <= 1'b0;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
            ACK0     <= 1'b0;
            ACK1     <= 1'b0;
            ERR0     <= 1'b0;
            ERR1     <= 1'b0;
            RDATA0   <= '0;
            RDATA1   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (any_req) begin
                        PWRITE   <= winner ? WR1 : WR0;
                        PADDR    <= winner ? ADDR1 : ADDR0;
                        PWDATA   <= winner ? WDATA1 : WDATA0;
                        GNT_ID   <= winner;
                        last_gnt <= winner;
                        PSEL     <= 1'b1;
                        wait_cnt <= '0;
                        state    <= StSetup;
                    end
                end
                StSetup: begin
                    PENABLE <= 1'b1;
                    state   <= StAccess;
                end
                StAccess: begin
                    if (finish) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        state   <= StDone;
                        if (GNT_ID) begin
                            ACK1 <= 1'b1;
                            ERR1 <= err_val;
                            if (!PWRITE) RDATA1 <= rdata_val;
                        end else begin
                            ACK0 <= 1'b1;
                            ERR0 <= err_val;
                            if (!PWRITE) RDATA0 <= rdata_val;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StDone: begin
                    // ERR is only meaningful alongside ACK, so both drop together.
                    ACK0  <= 1'b0;
                    ACK1  <= 1'b0;
                    ERR0  <= 1'b0;
                    ERR1  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_apb3_rr_master_arb.sv
// Directed bench for apb3_rr_master_arb: reset values, round-robin ties, a table of single
// transfers (waits, slave errors, timeouts) and a reset-during-ACCESS sequence.
module tb_apb3_rr_master_arb;

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          REQ0, WR0, REQ1, WR1;
    logic [AW-1:0] ADDR0, ADDR1;
    logic [DW-1:0] WDATA0, WDATA1;
    logic          ACK0, ERR0, ACK1, ERR1;
    logic [DW-1:0] RDATA0, RDATA1;
    logic          GNT_ID, PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;

    int tests = 0;
    int fails = 0;

    apb3_rr_master_arb #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .REQ0    (REQ0),
        .WR0     (WR0),
        .ADDR0   (ADDR0),
        .WDATA0  (WDATA0),
        .ACK0    (ACK0),
        .RDATA0  (RDATA0),
        .ERR0    (ERR0),
        .REQ1    (REQ1),
        .WR1     (WR1),
        .ADDR1   (ADDR1),
        .WDATA1  (WDATA1),
        .ACK1    (ACK1),
        .RDATA1  (RDATA1),
        .ERR1    (ERR1),
        .GNT_ID  (GNT_ID),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic          client;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] prdata;
        logic          slverr;
        int            waits;
        int            exp_access;
        int            exp_lat;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int  acc;
        int  psel_n;
        int  lat;
        bit  got;
        if (v.client) begin
            REQ1 = 1'b1; WR1 = v.wr; ADDR1 = v.addr; WDATA1 = v.wdata;
        end else begin
            REQ0 = 1'b1; WR0 = v.wr; ADDR0 = v.addr; WDATA0 = v.wdata;
        end
        PRDATA = v.prdata;
        PSLVERR = v.slverr;
        PREADY = 1'b0;
        acc = 0;
        psel_n = 0;
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            tick();
            if (PSEL) psel_n++;
            if (PSEL && PENABLE) begin
                acc++;
                if (acc == 1) begin
                    check("paddr", 64'(PADDR), 64'(v.addr));
                    check("pwrite", 64'(PWRITE), 64'(v.wr));
                    if (v.wr) check("pwdata", 64'(PWDATA), 64'(v.wdata));
                end
            end
            PREADY = PSEL && PENABLE && (acc > v.waits);
            if (ACK0 || ACK1) begin
                got = 1'b1;
                lat = k;
                check("ack_client", 64'(ACK1), 64'(v.client));
                check("ack_other", 64'(ACK0 & ACK1), 64'(0));
                check("gnt_id", 64'(GNT_ID), 64'(v.client));
                check("err", 64'(v.client ? ERR1 : ERR0), 64'(v.exp_err));
                check("err_other", 64'(v.client ? ERR0 : ERR1), 64'(0));
                check("rdata", 64'(v.client ? RDATA1 : RDATA0), 64'(v.exp_rdata));
                check("psel_done", 64'(PSEL | PENABLE), 64'(0));
                REQ0 = 1'b0;
                REQ1 = 1'b0;
                PREADY = 1'b0;
            end
        end
        check("ack_seen", 64'(got), 64'(1));
        check("access_cycles", 64'(acc), 64'(v.exp_access));
        check("psel_cycles", 64'(psel_n), 64'(v.exp_access + 1));
        check("ack_latency", 64'(lat), 64'(v.exp_lat));
        tick();
        check("ack_pulse", 64'({ACK0, ACK1, ERR0, ERR1}), 64'(0));
    endtask

    initial begin
        // client wr addr wdata prdata slverr waits access lat err rdata
        vecs[0] = '{1'b0, 1'b1, 24'h000010, 32'hA5A5_0001, 32'h0, 1'b0, 0, 1, 3, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 24'h000044, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 3, 5, 1'b0,
                    32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 1'b0, 24'h000123, 32'h0, 32'h1234_5678, 1'b0, 100, 8, 10, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 24'h000200, 32'h0, 32'hCAFE_F00D, 1'b0, 1, 2, 4, 1'b0,
                    32'hCAFE_F00D};
        vecs[4] = '{1'b1, 1'b1, 24'h000300, 32'h1111_2222, 32'h5555_5555, 1'b1, 0, 1, 3, 1'b1,
                    32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 1'b1, 24'hFFFFFC, 32'hFFFF_FFFF, 32'h7777_7777, 1'b0, 0, 1, 3, 1'b0,
                    32'hCAFE_F00D};
        vecs[6] = '{1'b1, 1'b0, 24'h000400, 32'h0, 32'h0BAD_F00D, 1'b1, 0, 1, 3, 1'b1,
                    32'h0BAD_F00D};
        vecs[7] = '{1'b1, 1'b1, 24'h000500, 32'h9999_8888, 32'h0, 1'b0, 100, 8, 10, 1'b1,
                    32'h0BAD_F00D};

        PRESET = 1'b1;
        REQ0 = 1'b0; WR0 = 1'b0; ADDR0 = '0; WDATA0 = '0;
        REQ1 = 1'b0; WR1 = 1'b0; ADDR1 = '0; WDATA1 = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        tick();
        tick();
        check("rst_psel", 64'(PSEL), 64'(0));
        check("rst_penable", 64'(PENABLE), 64'(0));
        check("rst_ack", 64'({ACK0, ACK1}), 64'(0));
        check("rst_err", 64'({ERR0, ERR1}), 64'(0));
        check("rst_gnt", 64'(GNT_ID), 64'(0));
        check("rst_pwrite", 64'(PWRITE), 64'(0));
        check("rst_paddr", 64'(PADDR), 64'(0));
        check("rst_pwdata", 64'(PWDATA), 64'(0));
        check("rst_rdata", 64'({RDATA0, RDATA1}), 64'(0));
        PRESET = 1'b0;

        // Both clients hold requests from reset: grants alternate starting with client 0.
        begin
            int   n0, n1, last_k;
            logic exp_c;
            n0 = 0; n1 = 0; last_k = -1; exp_c = 1'b0;
            REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = 24'h001000; WDATA0 = 32'h0000_0A00;
            REQ1 = 1'b1; WR1 = 1'b1; ADDR1 = 24'h002000; WDATA1 = 32'h0000_0B00;
            PREADY = 1'b1;
            for (int k = 0; k < 100 && (n0 < 4 || n1 < 4); k++) begin
                tick();
                if (ACK0 || ACK1) begin
                    check("rr_client", 64'(ACK1), 64'(exp_c));
                    check("rr_gnt", 64'(GNT_ID), 64'(exp_c));
                    if (last_k >= 0) check("rr_period", 64'(k - last_k), 64'(4));
                    last_k = k;
                    exp_c = ~exp_c;
                    if (ACK0) begin
                        n0++;
                        if (n0 == 4) REQ0 = 1'b0;
                        else ADDR0 = ADDR0 + 24'd4;
                    end
                    if (ACK1) begin
                        n1++;
                        if (n1 == 4) REQ1 = 1'b0;
                        else ADDR1 = ADDR1 + 24'd4;
                    end
                end
            end
            check("rr_count", 64'(n0 + n1), 64'(8));
            PREADY = 1'b0;
            tick();
        end

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset during ACCESS: bus drops next cycle, no ACK, and the tie restarts at client 0.
        begin
            bit seen;
            seen = 1'b0;
            REQ0 = 1'b1; WR0 = 1'b0; ADDR0 = 24'h000050;
            PREADY = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                tick();
                if (PSEL && PENABLE) seen = 1'b1;
            end
            check("rst_access_reached", 64'(seen), 64'(1));
            PRESET = 1'b1;
            REQ1 = 1'b1; WR1 = 1'b1; ADDR1 = 24'h000060;
            tick();
            check("midrst_psel", 64'(PSEL), 64'(0));
            check("midrst_penable", 64'(PENABLE), 64'(0));
            check("midrst_ack", 64'({ACK0, ACK1}), 64'(0));
            PRESET = 1'b0;
            tick();
            check("midrst_tie_gnt", 64'(GNT_ID), 64'(0));
            check("midrst_tie_psel", 64'({PSEL, PENABLE}), 64'(2));
            check("midrst_tie_paddr", 64'(PADDR), 64'(24'h000050));
            REQ0 = 1'b0;
            REQ1 = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
